// File: rtl/rr_chan_mux.sv
// N-to-1 channel mux, round-robin or fixed-priority arbitration, packet lock; optional RR_MUX_GRANT_CNT_EN counters.
// Latency: an accepted beat appears on out_* one cycle later; 1 beat/cycle with out_ready held high.
// Backpressure: out_valid && !out_ready holds the output register, drops every in_ready and freezes FSM/ptr.
module rr_chan_mux #(
    parameter int NUM_CH = 5,
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prio_mode,
    input  logic [NUM_CH-1:0]         in_valid,
    input  logic [NUM_CH-1:0]         in_last,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]         in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    input  logic                      out_ready,
    output logic [NUM_CH*CNT_W-1:0]   grant_cnt
);
    localparam int IDX_W = $clog2(NUM_CH);
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {ARB, LOCK} state_t;

    state_t state, state_nxt;
    idx_t   ptr, ptr_nxt;
    idx_t   lock_ch, lock_ch_nxt;
    logic   lock_mode, lock_mode_nxt;
    idx_t   lo_idx, hi_idx, sel;
    logic   lo_found, hi_found;
    logic   eff_mode, load, grant_en, accept, acc_last;

    // lo_* is the lowest valid index overall; hi_* the lowest valid index at or above ptr.
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = idx_t'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = idx_t'(i);
                end
            end
        end
    end

    // The mode captured at arbitration governs the whole packet, including the ptr update on its last beat.
    assign eff_mode = (state == ARB) ? prio_mode : lock_mode;
    assign load     = !out_valid || out_ready;
    assign grant_en = (state == LOCK) || lo_found;

    always_comb begin
        sel = lo_idx;
        if (state == LOCK) begin
            sel = lock_ch;
        end else if (!prio_mode && hi_found) begin
            sel = hi_idx;
        end
    end

    assign in_ready = (load && grant_en && !rst) ? (NUM_CH'(1) << sel) : '0;
    assign accept   = load && grant_en && !rst && in_valid[sel];
    assign acc_last = in_last[sel];

    always_comb begin
        state_nxt     = state;
        lock_ch_nxt   = lock_ch;
        lock_mode_nxt = lock_mode;
        ptr_nxt       = ptr;
        case (state)
            ARB: begin
                if (accept && !acc_last) begin
                    state_nxt     = LOCK;
                    lock_ch_nxt   = sel;
                    lock_mode_nxt = prio_mode;
                end
            end
            LOCK: begin
                if (accept && acc_last) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
        if (accept && acc_last && !eff_mode) begin
            ptr_nxt = (sel == idx_t'(NUM_CH - 1)) ? '0 : sel + idx_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            ptr       <= '0;
            lock_ch   <= '0;
            lock_mode <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            lock_ch   <= lock_ch_nxt;
            lock_mode <= lock_mode_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (load) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= in_data[int'(sel) * WIDTH +: WIDTH];
                out_last <= acc_last;
                out_ch   <= sel;
            end
        end
    end

`ifdef RR_MUX_GRANT_CNT_EN
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && sel == idx_t'(i) && cnt[i] != {CNT_W{1'b1}}) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign grant_cnt = cnt;
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_chan_mux.sv
// Directed vector bench for rr_chan_mux: RR fairness, packet lock, backpressure, mode switch, reset, counters.
module tb_rr_chan_mux;
    localparam int NUM_CH = 5;
    localparam int WIDTH  = 8;
`ifdef RR_MUX_GRANT_CNT_EN
    localparam int CNT_W  = 3;
`else
    localparam int CNT_W  = 16;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      prio_mode;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH-1:0]         in_last;
    logic [NUM_CH*WIDTH-1:0]   in_data;
    logic [NUM_CH-1:0]         in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic                      out_last;
    logic [$clog2(NUM_CH)-1:0] out_ch;
    logic                      out_ready;
    logic [NUM_CH*CNT_W-1:0]   grant_cnt;

    rr_chan_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .prio_mode(prio_mode),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
        .out_ready(out_ready), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              prio;
        logic [NUM_CH-1:0] valid;
        logic [NUM_CH-1:0] last;
        logic              ordy;
        logic [NUM_CH-1:0] exp_rdy;
        logic              exp_vld;
        int                exp_ch;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic p, input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] l,
                       input logic r, input logic [NUM_CH-1:0] er, input logic ev, input int ec);
        vq.push_back('{p, v, l, r, er, ev, ec});
    endtask

    // Each channel carries a fixed byte 0xA0+ch, so out_data follows from the expected channel.
    task automatic step(input vec_t v, input string tag);
        prio_mode = v.prio;
        in_valid  = v.valid;
        in_last   = v.last;
        out_ready = v.ordy;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_vld));
        if (v.exp_vld) begin
            chk({tag, " out_ch"}, 32'(out_ch), 32'(v.exp_ch));
            chk({tag, " out_data"}, 32'(out_data), 32'hA0 + 32'(v.exp_ch));
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
        rst = 1'b1; prio_mode = 1'b0; in_valid = '1; in_last = '1; out_ready = 1'b1;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_ch", 32'(out_ch), 32'h0);
        chk("reset out_data", 32'(out_data), 32'h0);
        chk("reset out_last", 32'(out_last), 32'h0);
        rst = 1'b0;

        // Round-robin fairness with single-beat packets.
        add(0, 5'b11111, 5'b11111, 1, 5'b00001, 1, 0);
        add(0, 5'b11111, 5'b11111, 1, 5'b00010, 1, 1);
        add(0, 5'b11111, 5'b11111, 1, 5'b00100, 1, 2);
        add(0, 5'b11111, 5'b11111, 1, 5'b01000, 1, 3);
        add(0, 5'b11111, 5'b11111, 1, 5'b10000, 1, 4);
        add(0, 5'b11111, 5'b11111, 1, 5'b00001, 1, 0);
        add(0, 5'b11111, 5'b11111, 1, 5'b00010, 1, 1);
        // ch2 3-beat packet with ch0/ch4 valid; ptr=2 going in.
        add(0, 5'b10101, 5'b10001, 1, 5'b00100, 1, 2);
        add(0, 5'b10101, 5'b10001, 1, 5'b00100, 1, 2);
        add(0, 5'b10101, 5'b10101, 1, 5'b00100, 1, 2);
        add(0, 5'b10001, 5'b10001, 1, 5'b10000, 1, 4);
        add(0, 5'b10001, 5'b10001, 1, 5'b00001, 1, 0);
        // Stall 4 cycles holding ch0's beat, then release: ptr still 1.
        for (int i = 0; i < 4; i++) add(0, 5'b11111, 5'b11111, 0, 5'b00000, 1, 0);
        add(0, 5'b11111, 5'b11111, 1, 5'b00010, 1, 1);
        add(0, 5'b11111, 5'b11111, 1, 5'b00100, 1, 2);
        // Fixed priority (ptr=3 held), then mode switch while ch3 is locked.
        for (int i = 0; i < 3; i++) add(1, 5'b01010, 5'b11111, 1, 5'b00010, 1, 1);
        add(1, 5'b01000, 5'b00000, 1, 5'b01000, 1, 3);
        add(0, 5'b01010, 5'b00000, 1, 5'b01000, 1, 3);
        add(0, 5'b00010, 5'b00000, 1, 5'b01000, 0, 0);
        add(0, 5'b01010, 5'b01010, 1, 5'b01000, 1, 3);
        add(0, 5'b01010, 5'b11111, 1, 5'b01000, 1, 3);
        add(0, 5'b01010, 5'b11111, 1, 5'b00010, 1, 1);
        add(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0);

        for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec%0d", i));

        // Reset while ch3 holds the lock with a beat in the output register.
        step('{0, 5'b01000, 5'b00000, 1, 5'b01000, 1, 3}, "pre_rst");
        rst = 1'b1; in_valid = '1; in_last = '0;
        #1;
        chk("rst_mid in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        chk("rst_mid out_valid", 32'(out_valid), 32'h0);
        chk("rst_mid out_ch", 32'(out_ch), 32'h0);
        chk("rst_mid out_data", 32'(out_data), 32'h0);
        rst = 1'b0;
        step('{0, 5'b01010, 5'b11111, 1, 5'b00010, 1, 1}, "post_rst_ptr");
        step('{0, 5'b10000, 5'b11111, 1, 5'b10000, 1, 4}, "post_rst_ch4");

`ifdef RR_MUX_GRANT_CNT_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) step('{0, 5'b00001, 5'b11111, 1, 5'b00001, 1, 0}, $sformatf("cnt%0d", i));
        chk("grant_cnt0 saturated", 32'(grant_cnt[0 +: CNT_W]), 32'd7);
        chk("grant_cnt others", 32'(|grant_cnt[NUM_CH*CNT_W-1:CNT_W]), 32'h0);
`else
        chk("grant_cnt zero", 32'(|grant_cnt), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
